writeback_pipe: RTL and testbench

WRITEBACK_PIPE -- requirements
Module: writeback_pipe

---
 rtl/wb_pkg.sv | 23 ++
 rtl/load_align.sv | 38 +++
 rtl/writeback_pipe.sv | 126 ++++++++++++
 tb/tb_writeback_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load encodings, FSM states and
// default widths.
package wb_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
  localparam int unsigned DEFAULT_RADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LD  = 3'b011,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101,
    LT_LWU = 3'b110
  } load_type_e;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the addressed byte/half/word out of an
// aligned memory word and sign- or zero-extends it to DATA_WIDTH.
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [2:0]                      load_type,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
  input  logic [DATA_WIDTH-1:0]           rdata,
  output logic [DATA_WIDTH-1:0]           data
);

  localparam int unsigned OFF_W = $clog2(DATA_WIDTH/8);
  localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
  // Only a 64-bit word holds two 32-bit lanes; on 32-bit the word is the whole bus.
  localparam logic [OFF_W-1:0] WORD_MASK = (DATA_WIDTH == 64) ? OFF_W'(3'b100) : '0;

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;

  always_comb begin
    b = 8'(rdata >> {offset, 3'b000});
    h = 16'(rdata >> {offset & HALF_MASK, 3'b000});
    w = 32'(rdata >> {offset & WORD_MASK, 3'b000});
    case (load_type_e'(load_type))
      LT_LB:   data = DATA_WIDTH'($signed(b));
      LT_LBU:  data = DATA_WIDTH'(b);
      LT_LH:   data = DATA_WIDTH'($signed(h));
      LT_LHU:  data = DATA_WIDTH'(h);
      LT_LW:   data = DATA_WIDTH'($signed(w));
      LT_LWU:  data = DATA_WIDTH'(w);
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_pipe.sv
// Writeback stage: registers ALU results or extracted load data into the
// register file, waiting in WAIT_LOAD for late memory responses.
module writeback_pipe
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned RADDR_WIDTH = DEFAULT_RADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   reg_web,
  input  logic                   mem_to_reg,
  input  logic [RADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0]  alu_result,
  input  logic [2:0]             load_type,
  input  logic                   mem_rvalid,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   reg_write,
  output logic [RADDR_WIDTH-1:0] reg_waddr,
  output logic [DATA_WIDTH-1:0]  reg_wdata,
  output logic                   busy
);

  localparam int unsigned OFF_W = $clog2(DATA_WIDTH/8);

  wb_state_e              state_q, state_d;
  logic [RADDR_WIDTH-1:0] cap_rd_q, cap_rd_d;
  logic [2:0]             cap_type_q, cap_type_d;
  logic [OFF_W-1:0]       cap_off_q, cap_off_d;

  logic                   wr_d;
  logic [RADDR_WIDTH-1:0] waddr_d;
  logic [DATA_WIDTH-1:0]  wdata_d;

  logic [2:0]             al_type;
  logic [OFF_W-1:0]       al_off;
  logic [DATA_WIDTH-1:0]  al_data;
  logic                   accept;

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_WAIT_LOAD);
  assign accept   = in_valid & in_ready & ~flush;

  // One aligner serves both paths: live inputs in IDLE, captured fields in WAIT_LOAD.
  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .load_type (al_type),
    .offset    (al_off),
    .rdata     (mem_rdata),
    .data      (al_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cap_rd_q   <= '0;
      cap_type_q <= '0;
      cap_off_q  <= '0;
      reg_write  <= 1'b0;
      reg_waddr  <= '0;
      reg_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      cap_rd_q   <= cap_rd_d;
      cap_type_q <= cap_type_d;
      cap_off_q  <= cap_off_d;
      reg_write  <= wr_d;
      reg_waddr  <= waddr_d;
      reg_wdata  <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_rd_d   = cap_rd_q;
    cap_type_d = cap_type_q;
    cap_off_d  = cap_off_q;
    wr_d       = 1'b0;
    waddr_d    = '0;
    wdata_d    = '0;
    al_type    = load_type;
    al_off     = alu_result[OFF_W-1:0];

    unique case (state_q)
      ST_IDLE: begin
        if (accept && reg_web) begin
          if (!mem_to_reg) begin
            wr_d    = 1'b1;
            waddr_d = rd;
            wdata_d = alu_result;
          end else if (mem_rvalid) begin
            wr_d    = 1'b1;
            waddr_d = rd;
            wdata_d = al_data;
          end else begin
            state_d    = ST_WAIT_LOAD;
            cap_rd_d   = rd;
            cap_type_d = load_type;
            cap_off_d  = alu_result[OFF_W-1:0];
          end
        end
      end
      ST_WAIT_LOAD: begin
        al_type = cap_type_q;
        al_off  = cap_off_q;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mem_rvalid) begin
          state_d = ST_IDLE;
          wr_d    = 1'b1;
          waddr_d = cap_rd_q;
          wdata_d = al_data;
        end
      end
    endcase

    // x0 is hardwired; a write to it collapses to the all-zero idle output.
    if (waddr_d == '0) begin
      wr_d    = 1'b0;
      wdata_d = '0;
    end
  end

endmodule

// File: tb/tb_writeback_pipe.sv
// Bench for writeback_pipe: a 32-bit and a 64-bit instance driven side by side
// and compared every cycle against a transaction-level model.
module tb_writeback_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       in_valid, flush, reg_web, mem_to_reg, mem_rvalid;
  logic [1:0][4:0]  rd;
  logic [1:0][2:0]  lt;
  logic [1:0][63:0] alu, rdata;

  logic        rdy32, busy32, wr32, rdy64, busy64, wr64;
  logic [4:0]  wa32, wa64;
  logic [31:0] wd32;
  logic [63:0] wd64;

  writeback_pipe #(.DATA_WIDTH(32), .RADDR_WIDTH(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rdy32), .flush(flush[0]),
    .reg_web(reg_web[0]), .mem_to_reg(mem_to_reg[0]), .rd(rd[0]), .alu_result(alu[0][31:0]),
    .load_type(lt[0]), .mem_rvalid(mem_rvalid[0]), .mem_rdata(rdata[0][31:0]),
    .reg_write(wr32), .reg_waddr(wa32), .reg_wdata(wd32), .busy(busy32)
  );

  writeback_pipe #(.DATA_WIDTH(64), .RADDR_WIDTH(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rdy64), .flush(flush[1]),
    .reg_web(reg_web[1]), .mem_to_reg(mem_to_reg[1]), .rd(rd[1]), .alu_result(alu[1]),
    .load_type(lt[1]), .mem_rvalid(mem_rvalid[1]), .mem_rdata(rdata[1]),
    .reg_write(wr64), .reg_waddr(wa64), .reg_wdata(wd64), .busy(busy64)
  );

  int errors = 0;
  int checks = 0;

  // Model: an outstanding load (if any) and the write expected after the last edge.
  bit          pend [2];
  logic [4:0]  p_rd [2];
  logic [2:0]  p_lt [2];
  int unsigned p_off[2];
  logic        e_wr [2];
  logic [4:0]  e_a  [2];
  logic [63:0] e_d  [2];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] extract(int unsigned w, logic [2:0] t, int unsigned off,
                                          logic [63:0] d);
    logic [63:0] v;
    int unsigned o;
    case (t)
      3'b000, 3'b100: begin
        v = (d >> (8 * off)) & 64'hFF;
        if (t == 3'b000 && v[7]) v = v | ~64'hFF;
      end
      3'b001, 3'b101: begin
        o = off & ~32'd1;
        v = (d >> (8 * o)) & 64'hFFFF;
        if (t == 3'b001 && v[15]) v = v | ~64'hFFFF;
      end
      3'b010, 3'b110: begin
        o = off & ~32'd3;
        v = (d >> (8 * o)) & 64'hFFFF_FFFF;
        if ((t == 3'b010 || w == 32) && v[31]) v = v | ~64'hFFFF_FFFF;
      end
      default: v = d;
    endcase
    if (w == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic model_step(int i);
    int unsigned w  = (i == 0) ? 32 : 64;
    logic [63:0] m  = (i == 0) ? 64'hFFFF_FFFF : '1;
    logic [63:0] a  = alu[i] & m;
    logic [63:0] d  = rdata[i] & m;
    logic        nw = 1'b0;
    logic [4:0]  na = '0;
    logic [63:0] nd = '0;
    if (rst) begin
      pend[i] = 1'b0;
    end else if (pend[i]) begin
      if (flush[i]) pend[i] = 1'b0;
      else if (mem_rvalid[i]) begin
        pend[i] = 1'b0;
        nw = 1'b1; na = p_rd[i]; nd = extract(w, p_lt[i], p_off[i], d);
      end
    end else if (in_valid[i] && !flush[i] && reg_web[i]) begin
      if (!mem_to_reg[i]) begin
        nw = 1'b1; na = rd[i]; nd = a;
      end else if (mem_rvalid[i]) begin
        nw = 1'b1; na = rd[i]; nd = extract(w, lt[i], int'(a % (w / 8)), d);
      end else begin
        pend[i] = 1'b1; p_rd[i] = rd[i]; p_lt[i] = lt[i]; p_off[i] = int'(a % (w / 8));
      end
    end
    if (na == 0) nw = 1'b0;
    if (!nw) begin na = '0; nd = '0; end
    e_wr[i] = nw; e_a[i] = na; e_d[i] = nd;
  endtask

  task automatic compare_all();
    chk("dut32 reg_write", 64'(wr32),   64'(e_wr[0]));
    chk("dut32 reg_waddr", 64'(wa32),   64'(e_a[0]));
    chk("dut32 reg_wdata", 64'(wd32),   e_d[0]);
    chk("dut32 busy",      64'(busy32), 64'(pend[0]));
    chk("dut32 in_ready",  64'(rdy32),  64'(!pend[0]));
    chk("dut64 reg_write", 64'(wr64),   64'(e_wr[1]));
    chk("dut64 reg_waddr", 64'(wa64),   64'(e_a[1]));
    chk("dut64 reg_wdata", wd64,        e_d[1]);
    chk("dut64 busy",      64'(busy64), 64'(pend[1]));
    chk("dut64 in_ready",  64'(rdy64),  64'(!pend[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    in_valid = '0; flush = '0; reg_web = '0; mem_to_reg = '0; mem_rvalid = '0;
    rd = '0; lt = '0; alu = '0; rdata = '0;
  endtask

  task automatic drive(int i, logic v, logic web, logic m2r, logic [4:0] r, logic [2:0] t,
                       logic [63:0] a, logic rv, logic [63:0] d);
    in_valid[i] = v; reg_web[i] = web; mem_to_reg[i] = m2r; rd[i] = r; lt[i] = t;
    alu[i] = a; mem_rvalid[i] = rv; rdata[i] = d;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; p_rd[i] = '0; p_lt[i] = '0; p_off[i] = 0;
      e_wr[i] = 1'b0; e_a[i] = '0; e_d[i] = '0;
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("reset reg_write", 64'(wr32), 64'd0);
    chk("reset reg_wdata", 64'(wd32), 64'd0);
    chk("reset busy",      64'(busy64), 64'd0);
    chk("reset in_ready",  64'(rdy32), 64'd1);
    rst = 1'b0;

    // ALU writeback, one cycle only
    drive(0, 1, 1, 0, 5'd5, 3'b000, 64'h1234_5678, 0, 0);
    tick();
    chk("alu reg_write", 64'(wr32), 64'd1);
    chk("alu reg_waddr", 64'(wa32), 64'd5);
    chk("alu reg_wdata", 64'(wd32), 64'h1234_5678);
    idle_inputs();
    tick();
    chk("alu single pulse", 64'(wr32), 64'd0);

    // LB / LBU, offset 3, data same cycle
    drive(0, 1, 1, 1, 5'd7, 3'b000, 64'd3, 1, 64'h80AB_CDEF);
    tick();
    chk("lb wdata", 64'(wd32), 64'hFFFF_FF80);
    drive(0, 1, 1, 1, 5'd7, 3'b100, 64'd3, 1, 64'h80AB_CDEF);
    tick();
    chk("lbu wdata", 64'(wd32), 64'h0000_0080);

    // LH, offset 2, data three cycles late
    drive(0, 1, 1, 1, 5'd9, 3'b001, 64'd2, 0, 64'h80AB_CDEF);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("lh wait busy", 64'(busy32), 64'd1);
      chk("lh wait in_ready", 64'(rdy32), 64'd0);
      chk("lh wait no write", 64'(wr32), 64'd0);
      idle_inputs();
    end
    drive(0, 0, 0, 0, 5'd0, 3'b000, 64'd0, 1, 64'h80AB_CDEF);
    tick();
    chk("lh late reg_write", 64'(wr32), 64'd1);
    chk("lh late reg_waddr", 64'(wa32), 64'd9);
    chk("lh late reg_wdata", 64'(wd32), 64'hFFFF_80AB);
    idle_inputs();
    tick();
    chk("lh one write", 64'(wr32), 64'd0);

    // flush wins over simultaneous rvalid in WAIT_LOAD
    drive(0, 1, 1, 1, 5'd10, 3'b010, 64'd0, 0, 0);
    tick();
    idle_inputs();
    flush[0] = 1'b1; mem_rvalid[0] = 1'b1; rdata[0] = 64'h1111_2222;
    tick();
    chk("flush no write", 64'(wr32), 64'd0);
    chk("flush idle", 64'(rdy32), 64'd1);
    flush[0] = 1'b0;
    tick();
    chk("stray rvalid ignored", 64'(wr32), 64'd0);
    idle_inputs();

    // rd=0 suppressed
    drive(0, 1, 1, 0, 5'd0, 3'b000, 64'hDEAD_BEEF, 0, 0);
    tick();
    chk("rd0 suppressed", 64'(wr32), 64'd0);
    chk("rd0 wdata zero", 64'(wd32), 64'd0);

    // reset while waiting for a load
    drive(0, 1, 1, 1, 5'd11, 3'b010, 64'd0, 0, 0);
    tick();
    idle_inputs();
    rst = 1'b1; mem_rvalid[0] = 1'b1; flush[0] = 1'b1; rdata[0] = 64'h5555_5555;
    tick();
    chk("rst wait no write", 64'(wr32), 64'd0);
    chk("rst wait waddr", 64'(wa32), 64'd0);
    chk("rst wait busy", 64'(busy32), 64'd0);
    rst = 1'b0;
    idle_inputs();
    tick();

    // 64-bit word loads, offset 4
    drive(1, 1, 1, 1, 5'd3, 3'b110, 64'd4, 1, 64'hF000_0001_DEAD_BEEF);
    tick();
    chk("lwu64 wdata", wd64, 64'h0000_0000_F000_0001);
    drive(1, 1, 1, 1, 5'd3, 3'b010, 64'd4, 1, 64'hF000_0001_DEAD_BEEF);
    tick();
    chk("lw64 wdata", wd64, 64'hFFFF_FFFF_F000_0001);
    drive(1, 1, 1, 1, 5'd3, 3'b011, 64'd5, 1, 64'hF000_0001_DEAD_BEEF);
    tick();
    chk("ld64 wdata", wd64, 64'hF000_0001_DEAD_BEEF);
    idle_inputs();
    tick();

    // randomized traffic on both instances
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        in_valid[i]   = ($urandom_range(0, 1) == 1);
        flush[i]      = ($urandom_range(0, 9) == 0);
        reg_web[i]    = ($urandom_range(0, 3) != 0);
        mem_to_reg[i] = ($urandom_range(0, 1) == 1);
        mem_rvalid[i] = ($urandom_range(0, 4) < 2);
        rd[i]         = 5'($urandom_range(0, 31));
        lt[i]         = 3'($urandom_range(0, 7));
        alu[i]        = {$urandom, $urandom};
        rdata[i]      = {$urandom, $urandom};
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
